// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, derived
// totals, counter width and a small decode helper.
package vga_timing_pkg;

    // Width of the x/y counters; both frame totals must fit in it.
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned CNT_LIMIT   = 1 << CNT_W;
    localparam int unsigned CLK_DIV_MAX = 16;

    // Default 640x480@60 timing, horizontal in pixels, vertical in lines.
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [CNT_W-1:0] cnt_t;

    // Registered decode outputs travel together as one record.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video;
    } sync_t;

    // Idle values: both syncs inactive (high), blanked video.
    localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, video: 1'b0};

    // Inclusive window test used for the sync pulse decodes.
    function automatic logic in_window(cnt_t v, cnt_t first, cnt_t last);
        return (v >= first) && (v <= last);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to its consumers (colour mux,
// connector pins, game logic). The master drives, slaves observe.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic hsync;
    logic vsync;
    logic video;
    cnt_t x;
    cnt_t y;
    logic p_tick;
    logic f_tick;

    modport master (
        output hsync,
        output vsync,
        output video,
        output x,
        output y,
        output p_tick,
        output f_tick
    );

    modport slave (
        input hsync,
        input vsync,
        input video,
        input x,
        input y,
        input p_tick,
        input f_tick
    );

endinterface

// File: rtl/vga_sync_gen_pix_tick.sv
// Pixel-rate enable: divides the system clock by CLK_DIV and raises
// p_tick for one clock in every CLK_DIV. p_tick is registered so that it
// is cleanly low during reset, including the CLK_DIV=1 case where it is
// otherwise permanently high.
module vga_pix_tick
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    if (CLK_DIV == 0 || CLK_DIV > CLK_DIV_MAX) begin : g_chk_div
        $error("vga_pix_tick: CLK_DIV must be in 1..16");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             p_tick_nxt;

    // Wrapping divider count and the enable decoded from its next value.
    always_comb begin
        div_nxt    = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        p_tick_nxt = (div_nxt == DIV_LAST);
    end

    // Divider state and registered enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            p_tick  <= p_tick_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: pixel enable, x/y raster counters,
// active-low hsync/vsync, visible-area flag and end-of-frame tick.
// Optional feature macro: VGA_SYNC_FRAME_TICK_EN (f_tick decode present
// when defined, f_tick tied low otherwise).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_chk_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (H_DISPLAY == 0 || V_DISPLAY == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_chk_width
        $error("vga_sync_gen: display and sync widths must be non-zero");
    end

    // Window bounds are kept inclusive so a 1024 total never needs an
    // 11-bit end value.
    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_LAST = cnt_t'(H_DISPLAY - 1);
    localparam cnt_t V_VIS_LAST = cnt_t'(V_DISPLAY - 1);
    localparam cnt_t HS_FIRST   = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_LAST    = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_FIRST   = cnt_t'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_LAST    = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic  p_tick;
    cnt_t  x_q;
    cnt_t  y_q;
    cnt_t  x_nxt;
    cnt_t  y_nxt;
    sync_t dec_q;
    sync_t dec_nxt;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Raster advance: x steps on every pixel enable, y steps when x wraps.
    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_nxt = x_q + 1'b1;
            end
        end
    end

    // Decode the next raster position so the registered syncs line up
    // with the x/y value loaded on the same edge.
    always_comb begin
        dec_nxt       = SYNC_RESET;
        dec_nxt.hsync = !in_window(x_nxt, HS_FIRST, HS_LAST);
        dec_nxt.vsync = !in_window(y_nxt, VS_FIRST, VS_LAST);
        dec_nxt.video = (x_nxt <= H_VIS_LAST) && (y_nxt <= V_VIS_LAST);
    end

    // Raster counters and registered decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dec_q <= SYNC_RESET;
        end else begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            dec_q <= dec_nxt;
        end
    end

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.hsync  = dec_q.hsync;
    assign vga.vsync  = dec_q.vsync;
    assign vga.video  = dec_q.video;
    assign vga.p_tick = p_tick;

`ifdef VGA_SYNC_FRAME_TICK_EN
    // Built from registered terms only; p_tick is low in reset, so no
    // partial tick can escape after a mid-frame reset.
    assign vga.f_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
`else
    assign vga.f_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen. Three instances share clock and
// reset: A uses the default 640x480 timing with CLK_DIV=4, B a 16x12
// raster with CLK_DIV=2, C the same raster with CLK_DIV=1. Expected
// samples are keyed by (reset epoch, clocks since reset release).
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef VGA_SYNC_FRAME_TICK_EN
    localparam logic FT = 1'b1;
`else
    localparam logic FT = 1'b0;
`endif

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen #(
        .CLK_DIV (4)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .vga   (if_a)
    );

    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .vga   (if_b)
    );

    vga_sync_gen #(
        .CLK_DIV   (1),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
    ) u_dut_c (
        .clk   (clk),
        .reset (reset),
        .vga   (if_c)
    );

    typedef enum int unsigned {
        W_A, W_B, W_C,
        W_A_PT_CNT, W_A_HS_LOW, W_A_VID_CNT,
        W_B_VS_LOW, W_B_VID_BAD, W_B_FT_CNT, W_B_FT_GAP,
        W_C_PT_LOW, W_C_FT_CNT, W_C_FT_GAP
    } what_e;

    typedef struct {
        int unsigned epoch;
        int unsigned cyc;
        what_e       what;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned epoch     = 0;
    int unsigned cyc       = 0;
    int unsigned checks    = 0;
    int unsigned failures  = 0;
    logic        drain_req = 1'b0;

    // Clock edges seen since reset was last released.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Running statistics over the post-edge state of each cycle.
    int unsigned a_pt_cnt = 0, a_hs_low = 0, a_vid_cnt = 0;
    int unsigned b_vs_low = 0, b_vid_bad = 0, b_ft_cnt = 0, b_ft_gap = 0, b_ft_last = 0;
    int unsigned c_pt_low = 0, c_ft_cnt = 0, c_ft_gap = 0, c_ft_last = 0;
    logic        b_ft_seen = 1'b0, c_ft_seen = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            a_pt_cnt <= 0; a_hs_low <= 0; a_vid_cnt <= 0;
            b_vs_low <= 0; b_vid_bad <= 0; b_ft_cnt <= 0; b_ft_gap <= 0; b_ft_last <= 0;
            c_pt_low <= 0; c_ft_cnt <= 0; c_ft_gap <= 0; c_ft_last <= 0;
            b_ft_seen <= 1'b0; c_ft_seen <= 1'b0;
        end else begin
            if (if_a.p_tick) a_pt_cnt <= a_pt_cnt + 1;
            if (!if_a.hsync) a_hs_low <= a_hs_low + 1;
            if (if_a.video)  a_vid_cnt <= a_vid_cnt + 1;
            if (!if_b.vsync) b_vs_low <= b_vs_low + 1;
            if (if_b.video && if_b.y >= 10'd6) b_vid_bad <= b_vid_bad + 1;
            if (if_b.f_tick) begin
                b_ft_cnt <= b_ft_cnt + 1;
                if (b_ft_seen) b_ft_gap <= cyc - b_ft_last;
                b_ft_seen <= 1'b1;
                b_ft_last <= cyc;
            end
            if (!if_c.p_tick) c_pt_low <= c_pt_low + 1;
            if (if_c.f_tick) begin
                c_ft_cnt <= c_ft_cnt + 1;
                if (c_ft_seen) c_ft_gap <= cyc - c_ft_last;
                c_ft_seen <= 1'b1;
                c_ft_last <= cyc;
            end
        end
    end

    function automatic logic [31:0] es(int unsigned x, int unsigned y, int unsigned hs,
                                       int unsigned vs, int unsigned vid, int unsigned pt,
                                       int unsigned ft);
        return {7'd0, ft[0], pt[0], vid[0], vs[0], hs[0], y[9:0], x[9:0]};
    endfunction

    function automatic logic [31:0] actual(what_e w);
        case (w)
            W_A:         return {7'd0, if_a.f_tick, if_a.p_tick, if_a.video, if_a.vsync, if_a.hsync, if_a.y, if_a.x};
            W_B:         return {7'd0, if_b.f_tick, if_b.p_tick, if_b.video, if_b.vsync, if_b.hsync, if_b.y, if_b.x};
            W_C:         return {7'd0, if_c.f_tick, if_c.p_tick, if_c.video, if_c.vsync, if_c.hsync, if_c.y, if_c.x};
            W_A_PT_CNT:  return a_pt_cnt;
            W_A_HS_LOW:  return a_hs_low;
            W_A_VID_CNT: return a_vid_cnt;
            W_B_VS_LOW:  return b_vs_low;
            W_B_VID_BAD: return b_vid_bad;
            W_B_FT_CNT:  return b_ft_cnt;
            W_B_FT_GAP:  return b_ft_gap;
            W_C_PT_LOW:  return c_pt_low;
            W_C_FT_CNT:  return c_ft_cnt;
            default:     return c_ft_gap;
        endcase
    endfunction

    task automatic push(int unsigned ep, int unsigned c, what_e w, logic [31:0] e, string n);
        exp_t it;
        it.epoch = ep;
        it.cyc   = c;
        it.what  = w;
        it.exp   = e;
        it.name  = n;
        sb.push_back(it);
    endtask

    // Monitor: samples away from the rising edge and right after reset
    // assertion, retiring every scoreboard entry due at this point.
    initial begin
        logic [31:0] got;
        while (!drain_req) begin
            @(negedge clk or negedge reset);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].epoch == epoch && sb[i].cyc == cyc) begin
                    got = actual(sb[i].what);
                    checks = checks + 1;
                    if (got !== sb[i].exp) begin
                        failures = failures + 1;
                        $display("FAIL %s: got 0x%08h expected 0x%08h (epoch %0d cycle %0d)",
                                 sb[i].name, got, sb[i].exp, epoch, cyc);
                    end
                    sb.delete(i);
                end
            end
        end
        foreach (sb[i]) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s: never sampled, expected 0x%08h at epoch %0d cycle %0d",
                     sb[i].name, sb[i].exp, sb[i].epoch, sb[i].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus: directed expectations, then reset sequencing.
    initial begin
        // Snapshot fields: x, y, hsync, vsync, video, p_tick, f_tick.
        push(1, 0,    W_A, es(0, 0, 1, 1, 0, 0, 0),     "a_reset");
        push(1, 1,    W_A, es(0, 0, 1, 1, 1, 0, 0),     "a_first_edge");
        push(1, 3,    W_A, es(0, 0, 1, 1, 1, 1, 0),     "a_ptick_c4");
        push(1, 4,    W_A, es(1, 0, 1, 1, 1, 0, 0),     "a_x1");
        push(1, 7,    W_A, es(1, 0, 1, 1, 1, 1, 0),     "a_ptick_c8");
        push(1, 8,    W_A, es(2, 0, 1, 1, 1, 0, 0),     "a_x2");
        push(1, 8,    W_A_PT_CNT, 32'd2,                "a_ptick_count8");
        push(1, 2559, W_A, es(639, 0, 1, 1, 1, 1, 0),   "a_last_visible");
        push(1, 2560, W_A, es(640, 0, 1, 1, 0, 0, 0),   "a_first_blank");
        push(1, 2623, W_A, es(655, 0, 1, 1, 0, 1, 0),   "a_pre_hsync");
        push(1, 2624, W_A, es(656, 0, 0, 1, 0, 0, 0),   "a_hsync_fall");
        push(1, 3007, W_A, es(751, 0, 0, 1, 0, 1, 0),   "a_hsync_last");
        push(1, 3008, W_A, es(752, 0, 1, 1, 0, 0, 0),   "a_hsync_rise");
        push(1, 3199, W_A_HS_LOW, 32'd384,              "a_hsync_low_clks");
        push(1, 3199, W_A_VID_CNT, 32'd2559,            "a_video_clks");
        push(1, 3200, W_A, es(0, 1, 1, 1, 1, 0, 0),     "a_line_wrap");

        push(1, 0,    W_B, es(0, 0, 1, 1, 0, 0, 0),     "b_reset");
        push(1, 255,  W_B, es(15, 7, 1, 1, 0, 1, 0),    "b_pre_vsync");
        push(1, 256,  W_B, es(0, 8, 1, 0, 0, 0, 0),     "b_vsync_fall");
        push(1, 319,  W_B, es(15, 9, 1, 0, 0, 1, 0),    "b_vsync_last");
        push(1, 320,  W_B, es(0, 10, 1, 1, 0, 0, 0),    "b_vsync_rise");
        push(1, 383,  W_B, es(15, 11, 1, 1, 0, 1, FT),  "b_frame_end");
        push(1, 384,  W_B, es(0, 0, 1, 1, 1, 0, 0),     "b_frame_wrap");
        push(1, 383,  W_B_VS_LOW, 32'd64,               "b_vsync_low_clks");
        push(1, 383,  W_B_VID_BAD, 32'd0,               "b_video_in_vblank");
        push(1, 800,  W_B_FT_CNT, FT ? 32'd2 : 32'd0,   "b_ftick_count");
        push(1, 800,  W_B_FT_GAP, FT ? 32'd384 : 32'd0, "b_ftick_period");

        push(1, 0,    W_C, es(0, 0, 1, 1, 0, 0, 0),     "c_reset");
        push(1, 1,    W_C, es(0, 0, 1, 1, 1, 1, 0),     "c_first_edge");
        push(1, 2,    W_C, es(1, 0, 1, 1, 1, 1, 0),     "c_x1");
        push(1, 192,  W_C, es(15, 11, 1, 1, 0, 1, FT),  "c_frame_end");
        push(1, 193,  W_C, es(0, 0, 1, 1, 1, 1, 0),     "c_frame_wrap");
        push(1, 800,  W_C_PT_LOW, 32'd0,                "c_ptick_low_clks");
        push(1, 800,  W_C_FT_CNT, FT ? 32'd4 : 32'd0,   "c_ftick_count");
        push(1, 800,  W_C_FT_GAP, FT ? 32'd192 : 32'd0, "c_ftick_period");

        push(2, 0,    W_A, es(0, 0, 1, 1, 0, 0, 0),     "a_async_reset");
        push(2, 0,    W_B, es(0, 0, 1, 1, 0, 0, 0),     "b_async_reset");
        push(2, 0,    W_C, es(0, 0, 1, 1, 0, 0, 0),     "c_async_reset");
        push(2, 1,    W_A, es(0, 0, 1, 1, 1, 0, 0),     "a_restart_edge");
        push(2, 3,    W_A, es(0, 0, 1, 1, 1, 1, 0),     "a_restart_ptick");
        push(2, 4,    W_A, es(1, 0, 1, 1, 1, 0, 0),     "a_restart_x1");
        push(2, 2,    W_B, es(1, 0, 1, 1, 1, 0, 0),     "b_restart_x1");
        push(2, 2,    W_C, es(1, 0, 1, 1, 1, 1, 0),     "c_restart_x1");
        push(2, 383,  W_B, es(15, 11, 1, 1, 0, 1, FT),  "b_restart_frame_end");
        push(2, 390,  W_B_FT_CNT, FT ? 32'd1 : 32'd0,   "b_restart_ftick_count");

        #3;
        epoch = 1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;

        // Mid-line reset, placed between clock edges.
        wait (cyc == 3210);
        #2;
        epoch = 2;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
        drain_req = 1'b1;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator for the 640x480@60 Hz VGA path of the pong game. Divides the 100 MHz system clock into a pixel-rate enable, runs horizontal and vertical counters, and drives `hsync`/`vsync` to the connector. Supplies the `x`, `y`, and `video` signals that the colour mux consumes. Also emits a one-cycle frame tick, which game logic uses to update paddle and ball positions between frames.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; legal range is 1..16.
- `H_DISPLAY`, `H_FRONT`, `H_SYNC`, `H_BACK`: 640, 16, 96, 48. Horizontal timing in pixels.
- `V_DISPLAY`, `V_FRONT`, `V_SYNC`, `V_BACK`: 480, 10, 2, 33. Vertical timing in lines.
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `video` out 1: high while (`x`,`y`) is inside the visible area.
- `x` out 10: current pixel column, 0..H_TOTAL-1.
- `y` out 10: current line, 0..V_TOTAL-1.
- `p_tick` out 1: pixel enable, high for 1 clk out of every CLK_DIV.
- `f_tick` out 1: end-of-frame pulse, 1 clk wide.

## Operation
- Derived totals:
  - H_TOTAL = sum of the four H_* parameters (800).
  - V_TOTAL = sum of the four V_* parameters (525).
  - Both totals must be ≤ 1024; elaboration fails otherwise.
- Divider:
  - `div_cnt` runs 0..CLK_DIV-1 and wraps to 0.
  - `p_tick = (div_cnt == CLK_DIV-1)`.
  - With CLK_DIV=1, `p_tick` is constantly high after reset.
- Counter advance happens on the clk edge that ends a `p_tick`-high cycle:
  - `x` increments, and wraps from H_TOTAL-1 to 0.
  - `y` increments only when `x` wraps, and itself wraps from V_TOTAL-1 to 0. `x` and `y` therefore wrap together at the frame corner.
- Decode. `hsync`, `vsync`, and `video` are registered. Each is loaded from the decode of the next-state counters, so it is aligned with the `x`/`y` values it describes:
  - `hsync` = 0 when H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - `vsync` = 0 when V_DISPLAY+V_FRONT ≤ y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - `video` = 1 when x < H_DISPLAY and y < V_DISPLAY.
- `f_tick` = `p_tick` AND x==H_TOTAL-1 AND y==V_TOTAL-1. It is high exactly in the last pixel-enable cycle of each frame.
- Arithmetic is unsigned and 10-bit; counters never exceed their total minus 1.

## Timing
- Reset values, asserted asynchronously: `div_cnt`=0, `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video`=0, `p_tick`=0, `f_tick`=0.
- First clk edge after reset release:
  - `video` becomes 1 (the decode of (0,0)).
  - `div_cnt` becomes 1.
  - With the default CLK_DIV=4, `p_tick` first rises in the 4th cycle after release.
- Latency is zero: `hsync`, `vsync`, and `video` change on the same edge as the `x`/`y` update they describe.
- Line period is H_TOTAL·CLK_DIV clk (3200). Frame period is H_TOTAL·V_TOTAL·CLK_DIV clk (1,680,000).
- Reset mid-frame: all state returns to reset values immediately. Timing restarts at (0,0) and no partial `f_tick` is emitted.

## Configuration
- `VGA_SYNC_FRAME_TICK_EN`:
  - Defined: `f_tick` behaves as in Operation.
  - Undefined: `f_tick` is tied to 0, and its decode logic is not synthesized.
  - The port exists in both builds.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL/V_TOTAL;
  - the counter width constant (10).
- One natural sub-module, `vga_pix_tick`: the parameterised CLK_DIV divider that produces `p_tick`.

## Test plan
- Reset, then release and run 8 clk (CLK_DIV=4):
  - `p_tick` is high exactly in cycles 4 and 8.
  - `x` goes 0→1→2; `video`=1 from the first edge.
- Run one line: `hsync`=0 exactly for x=656..751 (96 pixels = 384 clk), and `video`=0 for x≥640.
- Run to y=489, x=799 then one `p_tick`:
  - `vsync` falls at (0,490) and rises at (0,492).
  - `video` stays 0 for all y≥480.
- Run a full frame:
  - `f_tick` is high for exactly one clk, at x=799, y=524.
  - The next edge gives x=0, y=0, `video`=1.
  - Successive `f_tick` pulses are 1,680,000 clk apart.
- Assert `reset` low mid-line at x=300, y=200: all outputs take their reset values without waiting for a clk edge. After release, counting resumes from (0,0).
- CLK_DIV=1 build, and a build with `VGA_SYNC_FRAME_TICK_EN` undefined:
  - `p_tick` is constantly high; the frame is 420,000 clk.
  - `f_tick` never asserts in the undefined-macro build.
